// File: rtl/operandos_ula_if.sv
// ---------------------------------------------------------------------------
// operandos_ula_if
//
// Decode -> execute channel for the ALU operand register. Carries one decoded
// instruction per transfer under a valid/ready handshake.
//
//   in_valid        decode presents an instruction
//   in_ready        execute stage can accept this cycle
//   in_rs_val/rt    register-file read values (32)
//   in_imm          raw 16-bit immediate
//   in_rs/rt/rd     source and destination register numbers (5)
//   in_usa_imm      1 selects the extended immediate as operand B
//   in_ext_zero     1 zero-extends the immediate, 0 sign-extends it
//   in_ulacontrole  3-bit ALU op
//   in_cin          ALU carry-in
//
// Modports: master = decode side (drives the instruction),
//           slave  = operand register (drives in_ready).
// ---------------------------------------------------------------------------
interface operandos_ula_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_rs_val;
    logic [31:0] in_rt_val;
    logic [15:0] in_imm;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic        in_usa_imm;
    logic        in_ext_zero;
    logic [2:0]  in_ulacontrole;
    logic        in_cin;

    modport master (
        output in_valid, in_rs_val, in_rt_val, in_imm, in_rs, in_rt, in_rd,
               in_usa_imm, in_ext_zero, in_ulacontrole, in_cin,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_rs_val, in_rt_val, in_imm, in_rs, in_rt, in_rd,
               in_usa_imm, in_ext_zero, in_ulacontrole, in_cin,
        output in_ready
    );
endinterface

// File: rtl/operandos_ula.sv
// ---------------------------------------------------------------------------
// operandos_ula
//
// Execute-stage operand register in front of the 32-bit ALU. Holds one
// decoded instruction, picks register or extended immediate for operand B,
// and resolves RAW hazards by forwarding from EX/MEM (fw1) and MEM/WB (fw2).
//
// Parameters:
//   FORWARD_EN  1 enables the forwarding muxes, 0 passes stored values through
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   up                   decode channel (operandos_ula_if.slave)
//   flush                kills the held instruction and any same-cycle capture
//   fw1_we/reg/val       EX/MEM writeback candidate (highest priority)
//   fw2_we/reg/val       MEM/WB writeback candidate
//   out_valid/out_ready  downstream handshake
//   a, b, ULAcontrole,
//   cin, rd              ALU inputs and destination register
// ---------------------------------------------------------------------------
module operandos_ula #(
    parameter bit FORWARD_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    operandos_ula_if.slave     up,
    input  logic               flush,
    input  logic               fw1_we,
    input  logic [4:0]         fw1_reg,
    input  logic [31:0]        fw1_val,
    input  logic               fw2_we,
    input  logic [4:0]         fw2_reg,
    input  logic [31:0]        fw2_val,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        a,
    output logic [31:0]        b,
    output logic [2:0]         ULAcontrole,
    output logic               cin,
    output logic [4:0]         rd
);

    // Stored instruction fields
    logic [31:0] rs_val_reg;
    logic [31:0] rt_val_reg;
    logic [31:0] imm_ext_reg;
    logic [4:0]  rs_reg;
    logic [4:0]  rt_reg;
    logic [4:0]  rd_reg;
    logic        usa_imm_reg;
    logic [2:0]  ulacontrole_reg;
    logic        cin_reg;
    logic        valid_reg;

    logic        valid_next;
    logic [31:0] imm_ext_next;
    logic        capture;

    // Full-rate stream: an occupied stage still accepts when the occupant
    // leaves this same cycle.
    assign up.in_ready = !valid_reg || out_ready;

    // flush wins over an otherwise legal capture.
    assign capture = up.in_valid && up.in_ready && !flush;

    // Extension happens once at capture so the output path only sees a mux.
    assign imm_ext_next = up.in_ext_zero ? {16'h0000, up.in_imm}
                                         : {{16{up.in_imm[15]}}, up.in_imm};

    always_comb begin
        valid_next = valid_reg;
        if (flush) begin
            valid_next = 1'b0;
        end else if (capture) begin
            valid_next = 1'b1;
        end else if (out_ready) begin
            // Drain: the occupant leaves and nothing replaces it.
            valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rs_val_reg      <= '0;
            rt_val_reg      <= '0;
            imm_ext_reg     <= '0;
            rs_reg          <= '0;
            rt_reg          <= '0;
            rd_reg          <= '0;
            usa_imm_reg     <= 1'b0;
            ulacontrole_reg <= '0;
            cin_reg         <= 1'b0;
            valid_reg       <= 1'b0;
        end else begin
            valid_reg <= valid_next;
            if (capture) begin
                rs_val_reg      <= up.in_rs_val;
                rt_val_reg      <= up.in_rt_val;
                imm_ext_reg     <= imm_ext_next;
                rs_reg          <= up.in_rs;
                rt_reg          <= up.in_rt;
                rd_reg          <= up.in_rd;
                usa_imm_reg     <= up.in_usa_imm;
                ulacontrole_reg <= up.in_ulacontrole;
                cin_reg         <= up.in_cin;
            end
        end
    end

    // Forwarding muxes, index 0 = rs path (a), index 1 = rt path (b).
    // Evaluated every cycle on the stored register numbers so a held
    // instruction picks up results that retire while it waits.
    logic [4:0]  src_num [2];
    logic [31:0] src_val [2];
    logic [31:0] opnd    [2];

    assign src_num[0] = rs_reg;
    assign src_num[1] = rt_reg;
    assign src_val[0] = rs_val_reg;
    assign src_val[1] = rt_val_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            logic nonzero;
            logic hit1;
            logic hit2;

            // $zero is hard-wired, never a forwarding target.
            assign nonzero = (src_num[gi] != 5'd0);
            assign hit1    = FORWARD_EN && fw1_we && (fw1_reg == src_num[gi]) && nonzero;
            assign hit2    = FORWARD_EN && fw2_we && (fw2_reg == src_num[gi]) && nonzero;
            // EX/MEM is the younger result, so it takes priority.
            assign opnd[gi] = hit1 ? fw1_val :
                              hit2 ? fw2_val :
                                     src_val[gi];
        end
    endgenerate

    assign out_valid   = valid_reg;
    assign a           = opnd[0];
    assign b           = usa_imm_reg ? imm_ext_reg : opnd[1];
    assign ULAcontrole = ulacontrole_reg;
    assign cin         = cin_reg;
    assign rd          = rd_reg;

endmodule

// File: tb/tb_operandos_ula.sv
module tb_operandos_ula;

    typedef struct {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [31:0] imm_ext;
        logic        usa;
        logic [2:0]  op;
        logic        cin;
    } sb_entry_t;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        fw1_we;
    logic [4:0]  fw1_reg;
    logic [31:0] fw1_val;
    logic        fw2_we;
    logic [4:0]  fw2_reg;
    logic [31:0] fw2_val;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  ULAcontrole;
    logic        cin;
    logic [4:0]  rd;

    int checks_cnt;
    int fail_cnt;
    bit mon_en;
    sb_entry_t sb_q[$];

    operandos_ula_if dec_if ();

    operandos_ula #(.FORWARD_EN(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .up          (dec_if),
        .flush       (flush),
        .fw1_we      (fw1_we),
        .fw1_reg     (fw1_reg),
        .fw1_val     (fw1_val),
        .fw2_we      (fw2_we),
        .fw2_reg     (fw2_reg),
        .fw2_val     (fw2_val),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .a           (a),
        .b           (b),
        .ULAcontrole (ULAcontrole),
        .cin         (cin),
        .rd          (rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s = %h t=%0t", tag, got, $time);
        end
    endtask

    function automatic logic [31:0] ext_model(input logic [15:0] imm, input logic ez);
        if (ez) return {16'h0000, imm};
        return {{16{imm[15]}}, imm};
    endfunction

    function automatic logic [31:0] fwd_model(input logic [4:0] r, input logic [31:0] v);
        if (r == 5'd0) return v;
        if (fw1_we && fw1_reg == r) return fw1_val;
        if (fw2_we && fw2_reg == r) return fw2_val;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [4:0] rs_i, input logic [4:0] rt_i, input logic [4:0] rd_i,
                             input logic [31:0] rsv, input logic [31:0] rtv, input logic [15:0] imm,
                             input logic usa, input logic ez, input logic [2:0] op, input logic ci);
        dec_if.in_valid       = 1'b1;
        dec_if.in_rs          = rs_i;
        dec_if.in_rt          = rt_i;
        dec_if.in_rd          = rd_i;
        dec_if.in_rs_val      = rsv;
        dec_if.in_rt_val      = rtv;
        dec_if.in_imm         = imm;
        dec_if.in_usa_imm     = usa;
        dec_if.in_ext_zero    = ez;
        dec_if.in_ulacontrole = op;
        dec_if.in_cin         = ci;
    endtask

    task automatic idle();
        dec_if.in_valid = 1'b0;
    endtask

    task automatic fw_off();
        fw1_we = 1'b0; fw1_reg = 5'd0; fw1_val = 32'd0;
        fw2_we = 1'b0; fw2_reg = 5'd0; fw2_val = 32'd0;
    endtask

    // Scoreboard: accepted instructions pushed at the handshake, compared
    // against the ALU inputs every cycle they are live, popped on consume.
    sb_entry_t e;
    bit held;
    bit acc;
    sb_entry_t n;
    always @(negedge clk) begin
        if (mon_en) begin
            if (!rst_n) begin
                sb_q.delete();
            end else begin
                held = (sb_q.size() != 0);
                acc  = dec_if.in_valid && !flush && (!held || out_ready);
                chk("out_valid", 32'(out_valid), 32'(held));
                chk("in_ready", 32'(dec_if.in_ready), 32'(!held || out_ready));
                if (held) begin
                    e = sb_q[0];
                    chk("sb_a", a, fwd_model(e.rs, e.rs_val));
                    chk("sb_b", b, e.usa ? e.imm_ext : fwd_model(e.rt, e.rt_val));
                    chk("sb_op", 32'(ULAcontrole), 32'(e.op));
                    chk("sb_cin", 32'(cin), 32'(e.cin));
                    chk("sb_rd", 32'(rd), 32'(e.rd));
                    if (out_ready || flush) void'(sb_q.pop_front());
                end
                if (flush) sb_q.delete();
                if (acc) begin
                    n.rs      = dec_if.in_rs;
                    n.rt      = dec_if.in_rt;
                    n.rd      = dec_if.in_rd;
                    n.rs_val  = dec_if.in_rs_val;
                    n.rt_val  = dec_if.in_rt_val;
                    n.imm_ext = ext_model(dec_if.in_imm, dec_if.in_ext_zero);
                    n.usa     = dec_if.in_usa_imm;
                    n.op      = dec_if.in_ulacontrole;
                    n.cin     = dec_if.in_cin;
                    sb_q.push_back(n);
                end
            end
        end
    end

    initial begin
        checks_cnt = 0;
        fail_cnt   = 0;
        mon_en     = 1'b0;
        rst_n      = 1'b0;
        flush      = 1'b0;
        out_ready  = 1'b1;
        fw_off();
        set_instr(5'd3, 5'd4, 5'd5, 32'hDEAD_BEEF, 32'hCAFE_F00D, 16'h1234, 1'b0, 1'b0, 3'b010, 1'b1);

        // Reset held for two edges with a live instruction on the input
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_a", a, 32'd0);
        chk("rst_b", b, 32'd0);
        chk("rst_op", 32'(ULAcontrole), 32'd0);
        chk("rst_cin", 32'(cin), 32'd0);
        chk("rst_rd", 32'(rd), 32'd0);
        chk("rst_in_ready", 32'(dec_if.in_ready), 32'd1);
        rst_n = 1'b1;
        idle();
        mon_en = 1'b1;
        tick();

        // Streaming ADD then SUB, no bubble
        set_instr(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 16'h0, 1'b0, 1'b0, 3'b010, 1'b0);
        tick();
        set_instr(5'd5, 5'd6, 5'd7, 32'd9, 32'd3, 16'h0, 1'b0, 1'b0, 3'b110, 1'b1);
        #1;
        chk("stream_add_a", a, 32'd5);
        chk("stream_add_b", b, 32'd7);
        chk("stream_add_op", 32'(ULAcontrole), 32'd2);
        tick();
        idle();
        #1;
        chk("stream_sub_valid", 32'(out_valid), 32'd1);
        chk("stream_sub_a", a, 32'd9);
        chk("stream_sub_b", b, 32'd3);
        chk("stream_sub_op", 32'(ULAcontrole), 32'd6);
        tick();

        // Immediate extension; fw1 matching rt must not disturb b
        out_ready = 1'b0;
        set_instr(5'd1, 5'd6, 5'd8, 32'h10, 32'h55, 16'h8001, 1'b1, 1'b0, 3'b010, 1'b0);
        tick();
        idle();
        fw1_we = 1'b1; fw1_reg = 5'd6; fw1_val = 32'h0000_DEAD;
        #1;
        chk("imm_sext_b", b, 32'hFFFF_8001);
        tick();
        fw_off();
        out_ready = 1'b1;
        tick();
        set_instr(5'd1, 5'd6, 5'd8, 32'h10, 32'h55, 16'h8001, 1'b1, 1'b1, 3'b001, 1'b0);
        tick();
        idle();
        #1;
        chk("imm_zext_b", b, 32'h0000_8001);
        tick();

        // Forwarding priority
        out_ready = 1'b0;
        set_instr(5'd4, 5'd0, 5'd9, 32'h1111, 32'h0, 16'h0, 1'b0, 1'b0, 3'b010, 1'b0);
        tick();
        idle();
        fw1_we = 1'b1; fw1_reg = 5'd4; fw1_val = 32'h0000_AAAA;
        fw2_we = 1'b1; fw2_reg = 5'd4; fw2_val = 32'h0000_BBBB;
        #1;
        chk("fwd_prio_fw1", a, 32'h0000_AAAA);
        fw1_we = 1'b0;
        #1;
        chk("fwd_fw2_only", a, 32'h0000_BBBB);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        fw1_we = 1'b1; fw1_reg = 5'd0;
        fw2_we = 1'b1; fw2_reg = 5'd0;
        set_instr(5'd0, 5'd0, 5'd9, 32'h2222, 32'h3, 16'h0, 1'b0, 1'b0, 3'b000, 1'b0);
        tick();
        idle();
        #1;
        chk("fwd_zero_reg", a, 32'h2222);
        out_ready = 1'b1;
        fw_off();
        tick();

        // Backpressure with fw2 update during the hold
        out_ready = 1'b0;
        set_instr(5'd1, 5'd2, 5'd11, 32'h10, 32'h77, 16'h0, 1'b0, 1'b0, 3'b010, 1'b0);
        tick();
        set_instr(5'd7, 5'd8, 5'd12, 32'h99, 32'h5, 16'h0, 1'b0, 1'b0, 3'b100, 1'b0);
        #1;
        chk("bp_in_ready0", 32'(dec_if.in_ready), 32'd0);
        chk("bp_b_before", b, 32'h77);
        tick();
        fw2_we = 1'b1; fw2_reg = 5'd2; fw2_val = 32'h1234;
        #1;
        chk("bp_b_fw2", b, 32'h1234);
        chk("bp_rd_stable", 32'(rd), 32'd11);
        tick();
        #1;
        chk("bp_still_held", 32'(rd), 32'd11);
        chk("bp_in_ready1", 32'(dec_if.in_ready), 32'd0);
        out_ready = 1'b1;
        tick();
        fw_off();
        idle();
        #1;
        chk("bp_next_rd", 32'(rd), 32'd12);
        chk("bp_next_a", a, 32'h99);
        tick();

        // Flush collision
        set_instr(5'd1, 5'd2, 5'd9, 32'h4444, 32'h1, 16'h0, 1'b0, 1'b0, 3'b010, 1'b0);
        flush = 1'b1;
        #1;
        chk("flush_in_ready", 32'(dec_if.in_ready), 32'd1);
        tick();
        flush = 1'b0;
        set_instr(5'd3, 5'd2, 5'd10, 32'h3333, 32'h1, 16'h0, 1'b0, 1'b0, 3'b011, 1'b1);
        #1;
        chk("flush_dropped", 32'(out_valid), 32'd0);
        tick();
        idle();
        #1;
        chk("flush_next_valid", 32'(out_valid), 32'd1);
        chk("flush_next_rd", 32'(rd), 32'd10);
        chk("flush_next_a", a, 32'h3333);
        tick();

        // Reset during a hold discards the instruction
        out_ready = 1'b0;
        set_instr(5'd5, 5'd6, 5'd13, 32'h5555, 32'h6666, 16'h0, 1'b0, 1'b0, 3'b111, 1'b1);
        tick();
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("midhold_rst_valid", 32'(out_valid), 32'd0);
        chk("midhold_rst_a", a, 32'd0);
        tick();

        // Random traffic with backpressure and forwarding
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 2) != 0)
                set_instr(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                          $urandom, $urandom, 16'($urandom), 1'($urandom), 1'($urandom),
                          3'($urandom), 1'($urandom));
            else
                idle();
            out_ready = ($urandom_range(0, 3) != 0);
            fw1_we = 1'($urandom); fw1_reg = 5'($urandom_range(0, 7)); fw1_val = $urandom;
            fw2_we = 1'($urandom); fw2_reg = 5'($urandom_range(0, 7)); fw2_val = $urandom;
            tick();
        end
        idle();
        fw_off();
        out_ready = 1'b1;
        tick();
        tick();
        #1;
        chk("final_drained", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/operandos_ula.md
# operandos_ula

Execute-stage operand register for the MIPS datapath. Sits directly upstream of the 32-bit ALU. It captures decoded operands and control from the decode stage with a valid/ready handshake. It selects register or extended-immediate for operand B and resolves data hazards by forwarding from EX/MEM and MEM/WB. It then drives the ALU `a`, `b`, `cin` and 3-bit `ULAcontrole` inputs for one instruction per cycle.

## Interface
- `FORWARD_EN`, default 1: 1 enables the forwarding muxes; 0 drives stored register values unmodified.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  decode presents an instruction.
- `in_ready`  out  1  stage can accept this cycle.
- `in_rs_val`, `in_rt_val`  in  32  register-file read values.
- `in_imm`  in  16  instruction immediate.
- `in_rs`, `in_rt`, `in_rd`  in  5  source and destination register numbers.
- `in_usa_imm`  in  1  1 selects the extended immediate as operand B.
- `in_ext_zero`  in  1  1 zero-extends the immediate; 0 sign-extends it.
- `in_ulacontrole`  in  3  ALU op (000 AND, 001 OR, 010 ADD, 011 NOR, 100 XOR, 101 NAND, 110 SUB, 111 SLT).
- `in_cin`  in  1  ALU carry-in.
- `flush`  in  1  kill the held instruction.
- `fw1_we`, `fw1_reg` (5), `fw1_val` (32)  in  EX/MEM writeback candidate.
- `fw2_we`, `fw2_reg` (5), `fw2_val` (32)  in  MEM/WB writeback candidate.
- `out_valid`  out  1  ALU inputs hold a live instruction.
- `out_ready`  in  1  downstream consumes the instruction this cycle.
- `a`, `b`  out  32  ALU operands.
- `ULAcontrole`  out  3  ALU op.
- `cin`  out  1  ALU carry-in.
- `rd`  out  5  destination register, passed on to EX/MEM.

## Operation
- One-entry pipeline register. Stored fields: rs_val, rt_val, imm_ext (32), rs, rt, rd, usa_imm, ulacontrole, cin, valid.
- `in_ready = !out_valid || out_ready` (combinational; no bubble on a full-rate stream).
- Capture occurs when `in_valid && in_ready && !flush`. All fields load, and valid is set to 1.
- Hold occurs when `out_valid && !out_ready`. All fields keep their values, and `in_ready` is 0.
- Drain occurs when `out_valid && out_ready && !in_valid`. Valid clears; the other fields keep their values.
- Immediate extension is done at capture: `imm_ext = ext_zero ? {16'h0, imm} : {{16{imm[15]}}, imm}`.
- Forwarding is combinational on the outputs, every cycle, using the stored rs/rt. This keeps a held instruction current while upstream writers advance.
  - `a` = fw1_val if `fw1_we && fw1_reg==rs && rs!=0`.
  - Otherwise `a` = fw2_val if `fw2_we && fw2_reg==rs && rs!=0`.
  - Otherwise `a` = rs_val.
  - EX/MEM has priority over MEM/WB.
  - Register 0 is never forwarded.
- `b` = imm_ext when usa_imm is 1. No forwarding applies to the immediate.
- Otherwise `b` follows the same forwarding rule as `a`, using rt and rt_val.
- `ULAcontrole`, `cin` and `rd` are driven directly from the stored fields.

## Timing
- Latency 1: a capture at edge N gives `out_valid=1` and valid `a`/`b` after edge N.
- Throughput is 1 instruction/cycle while `out_ready=1`.
- The forwarding path is combinational from `fw*` to `a`/`b` within the cycle. It is the critical path into the ALU adder.
- `flush` acts at the edge and overrides everything:
  - valid becomes 0.
  - A simultaneous `in_valid` is not captured and is dropped, even though `in_ready` may be 1 that cycle.
- Reset (`rst_n=0` at an edge) overrides flush and capture. After the edge, all stored fields are 0 and `out_valid=0`.
  - Outputs after reset: `a=0`, `b=0`, `ULAcontrole=000`, `cin=0`, `rd=0`.
  - `in_ready=1` from the first cycle after reset.
- Reset asserted mid-hold discards the held instruction with no partial output.
- When `out_valid=0`, `a`/`b` still reflect the stale fields plus forwarding. Consumers must qualify them with `out_valid`.

## Test plan
- Reset: hold `rst_n=0` for 2 cycles with `in_valid=1`.
  - Expect `out_valid=0`, `a=b=0`, `ULAcontrole=000`, `in_ready=1` after release.
- Streaming: ADD with rs_val=5, rt_val=7 followed by SUB with rs_val=9, rt_val=3, `out_ready=1`.
  - Expect `a/b/ULAcontrole` of 5/7/010 then 9/3/110 on consecutive cycles, with no bubble.
- Immediate extension: imm=16'h8001, usa_imm=1.
  - ext_zero=0 gives `b=32'hFFFF8001`; ext_zero=1 gives `b=32'h00008001`.
  - fw1 matching rt does not change `b`.
- Forwarding priority: rs=4, fw1 (reg 4, val 0xAAAA) and fw2 (reg 4, val 0xBBBB) both enabled.
  - Expect `a=0xAAAA`.
  - fw1_we=0 gives `a=0xBBBB`.
  - With rs=0 and both fw matching reg 0, `a` equals the stored rs_val.
- Backpressure: `out_ready=0` for 3 cycles while holding an instruction with rt=2; fw2 writes reg 2 = 0x1234 during the hold.
  - Expect `in_ready=0` and the instruction stable.
  - `b` becomes 0x1234 in the same cycle fw2 asserts.
  - The next input is captured one cycle after `out_ready` returns to 1.
- Flush collision: assert `flush` together with `in_valid=1` and `in_ready=1`.
  - Expect `out_valid=0` next cycle and the incoming instruction absent.
  - An instruction offered the following cycle is captured normally.
